// File: rtl/dc_frame_packer.sv
// rtl/dc_frame_packer.sv - DC-frame / launch-command serialiser into a 32-bit FIFO
module dc_frame_packer #(
    parameter int          DAC_CHANNEL = 24,
    parameter int          FRAME_WORDS = 62,
    parameter logic [7:0]  HDR_LSB     = 8'h00
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_frame_req,
    input  logic [4:0]                   i_channel_sel,
    input  logic [FRAME_WORDS-1:0][31:0] i_dc_regs,
    input  logic                         i_launch_req,
    input  logic [3:0][31:0]             i_launch_cmd,
    output logic                         o_ready,
    output logic [31:0]                  o_fifo_data,
    output logic                         o_fifo_wr,
    input  logic                         i_fifo_full,
    output logic                         o_done,
    output logic                         o_err,
    output logic [15:0]                  o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HDR,
        S_SEND_PAYLOAD,
        S_SEND_MARK,
        S_SEND_LAUNCH
    } state_t;

    localparam logic [5:0]  LAST_IDX    = 6'(FRAME_WORDS - 1);
    localparam logic [5:0]  LAUNCH_LAST = 6'd3;
    localparam logic [31:0] MARKER      = 32'hFFFF_FFFF;

    state_t                        state_q;
    logic [5:0]                    idx_q;
    logic [31:0]                   hdr_q;
    logic [FRAME_WORDS-1:0][31:0]  regs_q;
    logic [3:0][31:0]              launch_q;
    logic                          done_q;
    logic                          err_q;
    logic [15:0]                   cnt_q;

    logic [31:0] hdr_d;
    logic        chan_ok;

    // One-cold channel field: exactly one zero, so a header never matches the marker
    assign hdr_d   = {~(24'd1 << i_channel_sel), HDR_LSB};
    assign chan_ok = (32'(i_channel_sel) < 32'(DAC_CHANNEL));

    // Sequencer: accept/latch in IDLE, then step one word per unblocked cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            hdr_q    <= '0;
            regs_q   <= '0;
            launch_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_launch_req) begin
                        launch_q <= i_launch_cmd;
                        idx_q    <= '0;
                        state_q  <= S_SEND_MARK;
                    end else if (i_frame_req) begin
                        if (chan_ok) begin
                            hdr_q   <= hdr_d;
                            regs_q  <= i_dc_regs;
                            idx_q   <= '0;
                            state_q <= S_SEND_HDR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SEND_HDR: begin
                    if (!i_fifo_full) begin
                        idx_q   <= '0;
                        state_q <= S_SEND_PAYLOAD;
                    end
                end
                S_SEND_PAYLOAD: begin
                    if (!i_fifo_full) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            cnt_q   <= cnt_q + 16'd1;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                S_SEND_MARK: begin
                    if (!i_fifo_full) begin
                        idx_q   <= '0;
                        state_q <= S_SEND_LAUNCH;
                    end
                end
                S_SEND_LAUNCH: begin
                    if (!i_fifo_full) begin
                        if (idx_q == LAUNCH_LAST) begin
                            idx_q   <= '0;
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                default: begin
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Word select follows state/index, so it holds naturally while the FIFO is full
    always_comb begin
        o_fifo_data = '0;
        case (state_q)
            S_SEND_HDR:     o_fifo_data = hdr_q;
            S_SEND_PAYLOAD: o_fifo_data = regs_q[idx_q];
            S_SEND_MARK:    o_fifo_data = MARKER;
            S_SEND_LAUNCH:  o_fifo_data = launch_q[idx_q[1:0]];
            default:        o_fifo_data = '0;
        endcase
    end

    assign o_fifo_wr   = (state_q != S_IDLE) && !i_fifo_full;
    assign o_ready     = (state_q == S_IDLE);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_dc_frame_packer.sv
// tb/tb_dc_frame_packer.sv - randomized self-checking bench for dc_frame_packer
module tb_dc_frame_packer;

    localparam int FW = 62;

    logic                 clk;
    logic                 rst_n;
    logic                 i_frame_req;
    logic [4:0]           i_channel_sel;
    logic [FW-1:0][31:0]  i_dc_regs;
    logic                 i_launch_req;
    logic [3:0][31:0]     i_launch_cmd;
    logic                 o_ready;
    logic [31:0]          o_fifo_data;
    logic                 o_fifo_wr;
    logic                 i_fifo_full;
    logic                 o_done;
    logic                 o_err;
    logic [15:0]          o_frame_cnt;

    dc_frame_packer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_frame_req   (i_frame_req),
        .i_channel_sel (i_channel_sel),
        .i_dc_regs     (i_dc_regs),
        .i_launch_req  (i_launch_req),
        .i_launch_cmd  (i_launch_cmd),
        .o_ready       (o_ready),
        .o_fifo_data   (o_fifo_data),
        .o_fifo_wr     (o_fifo_wr),
        .i_fifo_full   (i_fifo_full),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_frame_cnt   (o_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    int          exp_cnt = 0;
    int          hold_bad = 0;
    int          wr_full_bad = 0;
    bit          hold_win = 1'b0;
    bit          full_hist [100000];
    logic [31:0] wr_data [$];
    int          wr_cyc [$];
    int          err_hist [$];
    logic [31:0] exp_q [$];

    // Observer: every write, every err pulse, and the full flag per cycle
    always @(negedge clk) begin
        if (cyc < 100000) full_hist[cyc] = i_fifo_full;
        if (o_fifo_wr) begin
            wr_data.push_back(o_fifo_data);
            wr_cyc.push_back(cyc);
        end
        if (o_fifo_wr && i_fifo_full) wr_full_bad++;
        if (o_err) err_hist.push_back(cyc);
        if (hold_win && i_fifo_full && exp_q.size() > 21 && o_fifo_data !== exp_q[21]) hold_bad++;
    end

    function automatic logic [31:0] hdr_model(input int ch);
        logic [31:0] h;
        h = 32'hFFFF_FF00;
        h[8 + ch] = 1'b0;
        return h;
    endfunction

    // Words advance one per cycle with full low; done follows the last write
    function automatic int model_done(input int k, input int n);
        int t;
        int w;
        t = k;
        w = 0;
        while (w < n && t < 99999) begin
            if (!full_hist[t]) w++;
            t++;
        end
        return t;
    endfunction

    function automatic int first_diff(output logic [31:0] g, output logic [31:0] e);
        g = '0;
        e = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            if (i >= wr_data.size()) return i;
            g = wr_data[i];
            if (wr_data[i] !== exp_q[i]) return i;
        end
        if (wr_data.size() != exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic clear_obs();
        wr_data.delete();
        wr_cyc.delete();
        err_hist.delete();
        exp_q.delete();
    endtask

    task automatic load_frame(input int ch, input bit pat);
        logic [31:0] w;
        clear_obs();
        exp_q.push_back(hdr_model(ch));
        for (int i = 0; i < FW; i++) begin
            w = pat ? 32'h1000_0000 + 32'(i) : $urandom;
            i_dc_regs[i] = w;
            exp_q.push_back(w);
        end
        i_channel_sel = 5'(ch);
        i_frame_req   = 1'b1;
    endtask

    task automatic load_launch(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d);
        clear_obs();
        i_launch_cmd[0] = a;
        i_launch_cmd[1] = b;
        i_launch_cmd[2] = c;
        i_launch_cmd[3] = d;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        i_launch_req = 1'b1;
    endtask

    // mode 0: never full, 1: 10-cycle stall on payload 20 plus one toggle, 2: alternate, 3: random
    task automatic run_stream(input int mode, output int k, output int done_c);
        int stall_left;
        bit stalled;
        bit tog;
        bit first;
        stall_left = 0;
        stalled = 1'b0;
        tog = 1'b0;
        first = 1'b1;
        k = -1;
        done_c = -1;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (first) begin
                k = cyc;
                i_frame_req  = 1'b0;
                i_launch_req = 1'b0;
                first = 1'b0;
            end
            case (mode)
                0: i_fifo_full = 1'b0;
                1: begin
                    if (!stalled && wr_data.size() == 21) begin
                        stalled = 1'b1;
                        stall_left = 10;
                    end
                    hold_win = (stall_left > 0);
                    if (stall_left > 0) begin
                        i_fifo_full = 1'b1;
                        stall_left--;
                    end else if (!tog && wr_data.size() == 40) begin
                        i_fifo_full = 1'b1;
                        tog = 1'b1;
                    end else begin
                        i_fifo_full = 1'b0;
                    end
                end
                2: i_fifo_full = ~i_fifo_full;
                default: i_fifo_full = ($urandom_range(0, 99) < 30);
            endcase
            @(negedge clk);
            if (o_done) begin
                done_c = cyc;
                break;
            end
        end
        i_fifo_full = 1'b0;
        hold_win = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_frame_req = 1'b0;
        i_launch_req = 1'b0;
        i_channel_sel = '0;
        i_dc_regs = '0;
        i_launch_cmd = '0;
        i_fifo_full = 1'b0;
        #12;
        checks++;
        if ({o_ready, o_fifo_wr, o_done, o_err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1000", {o_ready, o_fifo_wr, o_done, o_err});
        end
        checks++;
        if (o_fifo_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00000000", o_fifo_data);
        end
        checks++;
        if (o_frame_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", o_frame_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_frame();
        int k, dc, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_frame(5, 1'b1);
        run_stream(0, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL frame_words idx=%0d got=%h exp=%h n=%0d", d, g, e, wr_data.size());
        end
        checks++;
        if (wr_data.size() != 63 || wr_data[0] !== 32'hFFFF_DF00 || wr_data[62] !== 32'h1000_003D) begin
            failures++;
            $display("FAIL frame_ends n=%0d exp=63 (hdr FFFFDF00, last 1000003D)", wr_data.size());
        end
        checks++;
        if (dc != k + 63) begin
            failures++;
            $display("FAIL frame_done got=%0d exp=%0d", dc, k + 63);
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_cnt) || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL frame_cnt got=%0d/%b exp=%0d/1", o_frame_cnt, o_ready, exp_cnt);
        end
    endtask

    task automatic test_launch();
        int k, dc, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_launch(32'hA, 32'hB, 32'hC, 32'hD);
        run_stream(0, k, dc);
        d = first_diff(g, e);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL launch_words idx=%0d got=%h exp=%h n=%0d", d, g, e, wr_data.size());
        end
        checks++;
        if (dc != k + 5) begin
            failures++;
            $display("FAIL launch_done got=%0d exp=%0d", dc, k + 5);
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL launch_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_priority();
        int k, dc, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_frame(0, 1'b0);
        load_launch($urandom, $urandom, $urandom, $urandom);
        run_stream(0, k, dc);
        d = first_diff(g, e);
        checks++;
        if (d != -1 || dc != k + 5) begin
            failures++;
            $display("FAIL prio_launch idx=%0d got=%h exp=%h done=%0d exp_done=%0d", d, g, e, dc, k + 5);
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL prio_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt);
        end
        @(posedge clk);
        #1;
        load_frame(0, 1'b0);
        run_stream(0, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1 || wr_data[0] !== 32'hFFFF_FE00) begin
            failures++;
            $display("FAIL prio_frame idx=%0d got=%h exp=%h hdr=%h", d, g, e, wr_data[0]);
        end
    endtask

    task automatic test_backpressure();
        int k, dc, d;
        logic [31:0] g, e;
        hold_bad = 0;
        wr_full_bad = 0;
        @(posedge clk);
        #1;
        load_frame($urandom_range(0, 23), 1'b0);
        run_stream(1, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL bp_words idx=%0d got=%h exp=%h n=%0d", d, g, e, wr_data.size());
        end
        checks++;
        if (dc != k + 63 + 11 || dc != model_done(k, 63)) begin
            failures++;
            $display("FAIL bp_done got=%0d exp=%0d", dc, k + 74);
        end
        checks++;
        if (hold_bad != 0 || wr_full_bad != 0) begin
            failures++;
            $display("FAIL bp_hold got=%0d/%0d exp=0/0", hold_bad, wr_full_bad);
        end
        checks++;
        if (o_frame_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL bp_cnt got=%0d exp=%0d", o_frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_toggle();
        int k, dc, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_frame($urandom_range(0, 23), 1'b0);
        run_stream(2, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1) begin
            failures++;
            $display("FAIL tog_words idx=%0d got=%h exp=%h n=%0d", d, g, e, wr_data.size());
        end
        checks++;
        if (dc != k + 126 || dc != model_done(k, 63)) begin
            failures++;
            $display("FAIL tog_done got=%0d exp=%0d", dc, k + 126);
        end
    endtask

    task automatic test_random();
        int k, dc, d;
        logic [31:0] g, e;
        bit is_launch;
        for (int it = 0; it < 6; it++) begin
            @(posedge clk);
            #1;
            is_launch = ($urandom_range(0, 1) == 1);
            if (is_launch) load_launch($urandom, $urandom, $urandom, $urandom);
            else load_frame($urandom_range(0, 23), 1'b0);
            run_stream(3, k, dc);
            if (!is_launch) exp_cnt++;
            d = first_diff(g, e);
            checks++;
            if (d != -1) begin
                failures++;
                $display("FAIL rand_words it=%0d idx=%0d got=%h exp=%h", it, d, g, e);
            end
            checks++;
            if (dc != model_done(k, exp_q.size()) || o_frame_cnt !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL rand_done it=%0d got=%0d/%0d exp=%0d/%0d", it, dc, o_frame_cnt,
                         model_done(k, exp_q.size()), exp_cnt);
            end
        end
    endtask

    task automatic test_bad_channel();
        int k, dc, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        clear_obs();
        i_channel_sel = 5'd24;
        i_frame_req = 1'b1;
        @(posedge clk);
        #1;
        i_frame_req = 1'b0;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_err got=%b/%b exp=1/1", o_err, o_ready);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_data.size() != 0 || err_hist.size() != 1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL bad_quiet writes=%0d errs=%0d exp=0/1", wr_data.size(), err_hist.size());
        end
        @(posedge clk);
        #1;
        load_frame(23, 1'b0);
        run_stream(0, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1 || wr_data[0] !== 32'h7FFF_FF00) begin
            failures++;
            $display("FAIL bad_then_23 idx=%0d got=%h exp=%h hdr=%h", d, g, e, wr_data[0]);
        end
    endtask

    task automatic test_back_to_back();
        int k1, d1, k2, d2, d;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_launch($urandom, $urandom, $urandom, $urandom);
        run_stream(0, k1, d1);
        d = first_diff(g, e);
        checks++;
        if (d != -1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_launch idx=%0d got=%h exp=%h ready=%b", d, g, e, o_ready);
        end
        load_frame($urandom_range(0, 23), 1'b0);
        run_stream(0, k2, d2);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1 || k2 != d1 + 1 || wr_cyc.size() == 0 || wr_cyc[0] != d1 + 1 || d2 != k2 + 63) begin
            failures++;
            $display("FAIL b2b_frame idx=%0d got=%h exp=%h start=%0d exp_start=%0d", d, g, e, k2, d1 + 1);
        end
    endtask

    task automatic test_reset_mid();
        int k, dc, d, n0;
        bit seen;
        logic [31:0] g, e;
        @(posedge clk);
        #1;
        load_frame($urandom_range(0, 23), 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            i_frame_req = 1'b0;
            if (wr_data.size() == 32) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_reach got=%0d exp=32", wr_data.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if ({o_fifo_wr, o_ready, o_done, o_err} !== 4'b0100 || o_fifo_data !== 32'h0 || o_frame_cnt !== 16'h0) begin
            failures++;
            $display("FAIL rst_async got=%b data=%h cnt=%0d exp=0100/0/0",
                     {o_fifo_wr, o_ready, o_done, o_err}, o_fifo_data, o_frame_cnt);
        end
        n0 = wr_data.size();
        repeat (3) @(negedge clk);
        checks++;
        if (wr_data.size() != n0) begin
            failures++;
            $display("FAIL rst_quiet got=%0d exp=%0d", wr_data.size(), n0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_frame($urandom_range(0, 23), 1'b0);
        run_stream(0, k, dc);
        exp_cnt++;
        d = first_diff(g, e);
        checks++;
        if (d != -1 || dc != k + 63 || o_frame_cnt !== 16'(exp_cnt)) begin
            failures++;
            $display("FAIL rst_restart idx=%0d got=%h exp=%h cnt=%0d exp_cnt=%0d", d, g, e, o_frame_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_launch();
        test_priority();
        test_backpressure();
        test_toggle();
        test_bad_channel();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dc_frame_packer.md
Name: dc_frame_packer

Overview:
- Transmit side of the DC-frame / launch-command FIFO stream.
- Captures a full DC register set for one DAC channel, or a 4-word launch command, and serialises it as 32-bit words into the dispatcher-side FIFO.
- Emits a one-cold channel header word, or the 0xFFFF_FFFF launch marker, ahead of each payload.
- Honours FIFO full back-pressure.

Parameters:
- DAC_CHANNEL, 24, number of DAC channels; header one-cold field width is fixed at 24 bits ([31:8]).
- FRAME_WORDS, 62, payload words following the header in a DC frame (frame = 1 + FRAME_WORDS words).
- HDR_LSB, 8'h00, constant placed in header bits [7:0].

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_req  in  1  request to send a DC frame; sampled only while o_ready=1.
- i_channel_sel  in  5  target channel, 0..DAC_CHANNEL-1.
- i_dc_regs  in  FRAME_WORDS x 32  payload words; index 0 is sent first.
- i_launch_req  in  1  request to send a launch command; sampled only while o_ready=1.
- i_launch_cmd  in  4 x 32  launch words; index 0 is sent first.
- o_ready  out  1  high in IDLE only.
- o_fifo_data  out  32  word to the FIFO.
- o_fifo_wr  out  1  FIFO write strobe.
- i_fifo_full  in  1  FIFO full flag.
- o_done  out  1  one-cycle pulse after the last word of a frame or launch command is written.
- o_err  out  1  one-cycle pulse on a rejected request.
- o_frame_cnt  out  16  count of completed DC frames; wraps.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, word index=0, capture buffers cleared.
  - o_ready=1, o_fifo_wr=0, o_fifo_data=0, o_done=0, o_err=0, o_frame_cnt=0.
- Accept, IDLE with o_ready=1, at rising edge:
  - If i_launch_req=1: latch i_launch_cmd and go to SEND_MARK. Launch has priority when both requests are high; the frame request is dropped and must be re-requested.
  - Else if i_frame_req=1 and i_channel_sel<DAC_CHANNEL:
    - Latch header = {~(24'b1<<i_channel_sel), HDR_LSB}.
    - Latch i_dc_regs and go to SEND_HDR.
  - Else if i_frame_req=1 and i_channel_sel>=DAC_CHANNEL: pulse o_err next cycle, stay in IDLE, write nothing.
- Inputs are don't-care once accepted. All sends come from the latched copies.
- Write rule:
  - o_fifo_wr = (state is a SEND_* state) && !i_fifo_full. This is combinational from the state register and i_fifo_full.
  - o_fifo_data = the latched word selected by the state and index. It is 0 in IDLE.
  - A word counts as written on any cycle with o_fifo_wr=1; the index or state advances at that edge.
  - While i_fifo_full=1, the state, index and o_fifo_data hold. Nothing is skipped or duplicated.
- States:
  - IDLE: wait for accept.
  - SEND_HDR: write the header word, then go to SEND_PAYLOAD with index=0.
  - SEND_PAYLOAD: write payload[index].
    - On the write with index=FRAME_WORDS-1: go to IDLE, pulse o_done next cycle, and o_frame_cnt+1 (modulo 2^16).
  - SEND_MARK: write 32'hFFFF_FFFF, then go to SEND_LAUNCH with index=0.
  - SEND_LAUNCH: write launch[index].
    - On the write with index=3: go to IDLE and pulse o_done next cycle. o_frame_cnt does not change.
- Latency, no back-pressure:
  - Accept edge k; first word write in cycle k+1.
  - Frame: FRAME_WORDS+1 consecutive write cycles (63 by default); o_done high in cycle k+64.
  - Launch: 5 write cycles; o_done high in cycle k+6.
  - o_ready returns high in the cycle after the last write, i.e. together with o_done. A new request may be accepted at that edge.
- Index counter is 6 bits and compares against FRAME_WORDS-1. FRAME_WORDS must be ≤63.
- Header guarantee: exactly one zero in [31:8], so a header can never equal the launch marker.
- Reset mid-send: the partial frame is abandoned and no further words are written. Stream resynchronisation at the receiver is a system-level concern and is not handled here.
- i_fifo_full toggling on every cycle: each low cycle writes exactly one word.

Test Plan:
- Frame ch=5, payload[i]=32'h1000_0000+i, FIFO never full → 63 writes. Word0=32'hFFFF_DF00, word1=32'h1000_0000, word62=32'h1000_003D. o_done at k+64; o_frame_cnt=1.
- Launch {32'hA,32'hB,32'hC,32'hD} → 5 writes: FFFF_FFFF, A, B, C, D. o_done at k+6; o_frame_cnt unchanged.
- Frame and launch requests in the same cycle, ch=0 → only the launch sequence is written. Next frame request with ch=0 gives header 32'hFFFF_FE00.
- i_fifo_full high for 10 cycles during payload word 20, with one extra toggle mid-stream → word 20 held stable. Total writes=63 with no gaps in values. o_done delayed by exactly the full-cycle count.
- i_channel_sel=24 → o_err pulse, zero writes, o_ready stays 1. Then ch=23 → header 32'h7FFF_FF00.
- i_rst_n low after payload word 30 → o_fifo_wr=0 immediately (async), all outputs at reset values. The next frame starts cleanly with its header.
